// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, entry FSM states
// and code classification helpers.
package keypad_pkg;

    localparam logic [3:0] KEY_IDLE      = 4'd13;
    localparam logic [3:0] KEY_BACKSPACE = 4'd10;
    localparam logic [3:0] KEY_ENTER     = 4'd11;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    typedef enum logic {
        ENTRY,
        HOLD
    } entry_state_t;

    function automatic logic is_key(input logic [3:0] code);
        return code <= KEY_ENTER;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

    // Codes 12, 14 and 15 never come from a healthy encoder.
    function automatic logic [3:0] sanitize(input logic [3:0] code);
        return is_key(code) ? code : KEY_IDLE;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Input register, debounce counter, stable code and
// one-pulse-per-press generation for the keypad code.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic [3:0] stable_code,
    output logic       press,
    output logic       key_valid,
    output logic [3:0] key_value
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sample;
    logic [3:0]       sync_code;
    logic [3:0]       prev_stable;
    logic [CNT_W-1:0] cnt;
    logic             same;

    assign sample = sanitize(key_code);
    assign same   = (sample == sync_code);

    // A new key, or a key after idle, is a press; holding is not.
    assign press = (stable_code != prev_stable) && is_key(stable_code);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_code   <= KEY_IDLE;
            cnt         <= '0;
            stable_code <= KEY_IDLE;
            prev_stable <= KEY_IDLE;
            key_valid   <= 1'b0;
            key_value   <= 4'd0;
        end else begin
            sync_code   <= sample;
            prev_stable <= stable_code;
            key_valid   <= press;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (same && cnt == CNT_LOAD) begin
                stable_code <= sync_code;
            end
            if (press) begin
                key_value <= stable_code;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_decoder.sv
// Keypad consumer: debounced press events, one-hot decode
// and a BCD digit entry buffer held until acknowledged.
module keypad_entry_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [3:0]                        key_code,
    input  logic                              entry_ack,
    output logic [11:0]                       key_onehot,
    output logic                              key_valid,
    output logic [3:0]                        key_value,
    output logic [4*MAX_DIGITS-1:0]           digits,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              entry_ready,
    output logic                              overflow
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_DIGITS);

    logic [3:0]   stable_code;
    logic         press;
    entry_state_t state;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset      (reset),
        .key_code   (key_code),
        .stable_code(stable_code),
        .press      (press),
        .key_valid  (key_valid),
        .key_value  (key_value)
    );

    // Buffer and overflow act on the same edge that raises key_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ENTRY;
            key_onehot  <= '0;
            digits      <= '0;
            digit_count <= '0;
            entry_ready <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow   <= 1'b0;
            key_onehot <= is_key(stable_code) ?
                          (12'd1 << stable_code) : 12'd0;
            unique case (state)
                ENTRY: begin
                    if (press) begin
                        unique case (1'b1)
                            is_digit(stable_code): begin
                                if (digit_count != FULL) begin
                                    digits      <= (digits << 4)
                                                 | DW'(stable_code);
                                    digit_count <= digit_count + CW'(1);
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            stable_code == KEY_BACKSPACE: begin
                                if (digit_count != '0) begin
                                    digits      <= digits >> 4;
                                    digit_count <= digit_count - CW'(1);
                                end
                            end
                            stable_code == KEY_ENTER: begin
                                if (digit_count != '0) begin
                                    entry_ready <= 1'b1;
                                    state       <= HOLD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HOLD: begin
                    if (entry_ack) begin
                        digits      <= '0;
                        digit_count <= '0;
                        entry_ready <= 1'b0;
                        state       <= ENTRY;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Directed bench for keypad_entry_decoder with
// DEBOUNCE_CYCLES = 4 and MAX_DIGITS = 4.
module tb_keypad_entry_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  key_code;
    logic        entry_ack;
    logic [11:0] key_onehot;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        entry_ready;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;
    int ocnt   = 0;
    int obth   = 0;
    int v0, o0, b0;

    keypad_entry_decoder #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_code   (key_code),
        .entry_ack  (entry_ack),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .digits     (digits),
        .digit_count(digit_count),
        .entry_ready(entry_ready),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_valid) vcnt++;
        if (overflow) ocnt++;
        if (overflow && key_valid) obth++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_code = k;
        tick(8);
        key_code = 4'd13;
        tick(8);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_kv"},  32'(key_valid),   0);
        chk({tag, "_kval"}, 32'(key_value),  0);
        chk({tag, "_oh"},  32'(key_onehot),  0);
        chk({tag, "_dig"}, 32'(digits),      0);
        chk({tag, "_cnt"}, 32'(digit_count), 0);
        chk({tag, "_rdy"}, 32'(entry_ready), 0);
        chk({tag, "_ovf"}, 32'(overflow),    0);
    endtask

    initial begin
        reset     = 1'b1;
        key_code  = 4'd13;
        entry_ack = 1'b0;
        #2;
        chk_zero("rst");
        tick(2);
        reset = 1'b0;
        tick(2);

        v0 = vcnt;
        key_code = 4'd5;
        tick(5);
        chk("t1_kv_early", 32'(key_valid), 0);
        tick(1);
        chk("t1_kv",   32'(key_valid),   1);
        chk("t1_kval", 32'(key_value),   5);
        chk("t1_oh",   32'(key_onehot),  32'h020);
        chk("t1_dig",  32'(digits),      32'h0005);
        chk("t1_cnt",  32'(digit_count), 1);
        tick(1);
        chk("t1_kv_drop", 32'(key_valid), 0);
        tick(3);
        key_code = 4'd13;
        tick(8);
        chk("t1_once",    vcnt - v0,        1);
        chk("t1_oh_idle", 32'(key_onehot),  0);

        v0 = vcnt;
        key_code = 4'd7;
        tick(3);
        chk("t2_oh_mid", 32'(key_onehot), 0);
        key_code = 4'd13;
        tick(8);
        chk("t2_novalid", vcnt - v0,       0);
        chk("t2_oh",      32'(key_onehot), 0);
        chk("t2_dig",     32'(digits),     32'h0005);

        press(4'd10);
        chk("clr_dig", 32'(digits),      0);
        chk("clr_cnt", 32'(digit_count), 0);

        v0 = vcnt; o0 = ocnt; b0 = obth;
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        chk("t3_dig4",  32'(digits),      32'h1234);
        chk("t3_cnt4",  32'(digit_count), 4);
        chk("t3_noovf", ocnt - o0,        0);
        press(4'd5);
        chk("t3_dig5",  32'(digits),      32'h1234);
        chk("t3_cnt5",  32'(digit_count), 4);
        chk("t3_ovf",   ocnt - o0,        1);
        chk("t3_ovfkv", obth - b0,        1);
        chk("t3_vcnt",  vcnt - v0,        5);

        repeat (4) press(4'd10);
        chk("t4_clr_dig", 32'(digits),      0);
        chk("t4_clr_cnt", 32'(digit_count), 0);
        press(4'd9);
        press(4'd8);
        press(4'd10);
        chk("t4_dig", 32'(digits),      32'h0009);
        chk("t4_cnt", 32'(digit_count), 1);
        press(4'd10);
        press(4'd10);
        chk("t4_under_dig", 32'(digits),      0);
        chk("t4_under_cnt", 32'(digit_count), 0);

        press(4'd4);
        press(4'd2);
        press(4'd11);
        chk("t5_rdy", 32'(entry_ready), 1);
        chk("t5_dig", 32'(digits),      32'h0042);
        chk("t5_cnt", 32'(digit_count), 2);
        v0 = vcnt; o0 = ocnt;
        press(4'd6);
        chk("t5_hold_kv",   vcnt - v0,        1);
        chk("t5_hold_kval", 32'(key_value),   6);
        chk("t5_hold_dig",  32'(digits),      32'h0042);
        chk("t5_hold_rdy",  32'(entry_ready), 1);
        chk("t5_hold_ovf",  ocnt - o0,        0);
        entry_ack = 1'b1;
        tick(1);
        entry_ack = 1'b0;
        chk("t5_ack_dig", 32'(digits),      0);
        chk("t5_ack_cnt", 32'(digit_count), 0);
        chk("t5_ack_rdy", 32'(entry_ready), 0);
        press(4'd7);
        entry_ack = 1'b1;
        tick(1);
        entry_ack = 1'b0;
        chk("t5_ackent_dig", 32'(digits),      32'h0007);
        chk("t5_ackent_cnt", 32'(digit_count), 1);

        press(4'd11);
        chk("t5b_rdy", 32'(entry_ready), 1);
        key_code = 4'd1;
        tick(5);
        entry_ack = 1'b1;
        tick(1);
        entry_ack = 1'b0;
        chk("t5b_kv",   32'(key_valid),   1);
        chk("t5b_kval", 32'(key_value),   1);
        chk("t5b_dig",  32'(digits),      0);
        chk("t5b_cnt",  32'(digit_count), 0);
        chk("t5b_rdy0", 32'(entry_ready), 0);
        tick(1);
        chk("t5b_dig_after", 32'(digits), 0);
        key_code = 4'd13;
        tick(8);

        press(4'd5);
        key_code = 4'd3;
        tick(8);
        chk("t6_dig", 32'(digits),      32'h0053);
        chk("t6_cnt", 32'(digit_count), 2);
        reset = 1'b1;
        #1;
        chk_zero("t6_rst");
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("t6_kv_early", 32'(key_valid), 0);
        tick(1);
        chk("t6_kv",   32'(key_valid),   1);
        chk("t6_kval", 32'(key_value),   3);
        chk("t6_dig2", 32'(digits),      32'h0003);
        chk("t6_cnt2", 32'(digit_count), 1);
        tick(1);
        chk("t6_oh", 32'(key_onehot), 32'h008);
        key_code = 4'd13;
        tick(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_decoder.md
Name: keypad_entry_decoder

Overview:
- Consumer end of the keypad priority-encoder interface: receives the 4-bit key code (0–11 = key, 13 = nothing pressed) and debounces it.
- Emits one event per press, decodes the stable code back to a one-hot key vector, and assembles digit keys into a multi-digit BCD entry (PIN / amount) for the processor.
- Key 10 = backspace, key 11 = enter; entry is held until the processor acknowledges it.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive identical samples required before a code is accepted as stable (min 2).
- MAX_DIGITS, 4, capacity of the entry buffer in BCD digits (min 1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clock, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- key_code, input, 4, encoder output; 0–11 key, 13 idle; 12/14/15 treated as idle.
- entry_ack, input, 1, processor acknowledges held entry; clears buffer.
- key_onehot, output, 12, one-hot of current stable key; 0 when stable idle.
- key_valid, output, 1, one-cycle pulse per accepted press.
- key_value, output, 4, code of last accepted press; valid with key_valid, held after.
- digits, output, 4*MAX_DIGITS, BCD entry; newest digit in [3:0], unused digits 0.
- digit_count, output, $clog2(MAX_DIGITS+1), digits currently held.
- entry_ready, output, 1, level; entry complete and held awaiting entry_ack.
- overflow, output, 1, one-cycle pulse when a digit is pressed with buffer full.

Behaviour:
- Reset (async, immediate):
  - sample register = 13, stable_code = 13, counter = 0, state = ENTRY.
  - All outputs 0 except key_value = 0.
- Input stage:
  - key_code is registered once (sync_code); invalid codes 12/14/15 map to 13 at this register.
- Debounce:
  - Counter clears when sync_code differs from its previous value; otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - stable_code loads sync_code on the cycle the counter reaches DEBOUNCE_CYCLES-1 with an equal sample, i.e. after DEBOUNCE_CYCLES equal samples.
  - Any shorter glitch never reaches stable_code.
- Press event:
  - key_valid pulses on the cycle after stable_code changes to a value 0–11 from any other value, including a direct key-to-key change.
  - key_value updates on that same cycle.
  - Holding a key produces no repeat.
  - Latency from a clean input change to key_valid = DEBOUNCE_CYCLES + 2 clocks.
- key_onehot: registered decode of stable_code; bit n = 1 iff stable_code == n.
- FSM state ENTRY, on each press event:
  - Digit 0–9 with digit_count < MAX_DIGITS: digits shift left 4, new digit into [3:0], count+1.
  - Digit 0–9 with digit_count == MAX_DIGITS: buffer unchanged, overflow pulses with key_valid.
  - Key 10 (backspace): digits shift right 4 with zero fill, count−1; no effect at count 0.
  - Key 11 (enter): with count > 0, entry_ready = 1 and go to HOLD; ignored at count 0.
- FSM state HOLD:
  - Presses still pulse key_valid and key_value but never modify digits or count; no overflow.
  - entry_ack = 1: digits = 0, count = 0, entry_ready = 0 on the next edge; go to ENTRY.
  - entry_ack and a press event in the same cycle: ack wins; the press is not applied to the buffer, but key_valid still pulses.
- entry_ack in ENTRY: ignored.
- Reset mid-press or mid-entry: everything cleared. A key still held after reset deasserts is accepted as a new press once debounced.

Decomposition:
- Shared package (keypad_pkg):
  - KEY_IDLE = 4'd13, KEY_BACKSPACE = 4'd10, KEY_ENTER = 4'd11, KEY_DIGIT_MAX = 4'd9.
  - FSM state enum {ENTRY, HOLD}.
  - The encoder and this block both use the package.
- One sub-module: key_debouncer, containing the sync register, counter, stable_code and press-pulse generation.
- Entry buffer, FSM and one-hot decode stay in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, MAX_DIGITS = 4):
- Hold key_code = 5 for 10 clocks from idle 13 -> exactly one key_valid with key_value = 5, 6 clocks after the change; key_onehot = 12'h020; digits = 16'h0005; count = 1.
- Glitch key_code = 7 for 3 clocks between idle -> no key_valid; key_onehot stays 0; stable_code stays 13.
- Press 1, 2, 3, 4, 5 (idle between each) -> digits = 16'h1234; count = 4; overflow pulses once on the fifth press; digits unchanged.
- Press 9, 8, then 10 -> digits = 16'h0009; count = 1. Press 10 twice more -> digits 0, count 0, no underflow.
- Press 4, 2, then 11 -> entry_ready = 1, digits = 16'h0042. Press 6 -> key_valid pulses, digits unchanged. Pulse entry_ack -> digits 0, count 0, entry_ready = 0 next cycle.
- Assert reset while key 3 is held and count = 2 -> all outputs 0 immediately. Release reset with 3 still held -> key_valid after 6 clocks; digits = 16'h0003.
